// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Serial program loader for the instruction memory of the single-cycle
// datapath. A framed byte stream arrives over a valid/ready handshake:
//
//    START_BYTE, N, 4*N data bytes (MSB first), XOR checksum of data bytes
//
// Each group of four data bytes becomes one 32-bit instruction word. Words
// are written at consecutive word addresses starting at 0. The datapath is
// held in reset while a load is running and after a failed load.
//
// Ports
//    clock     : single clock, rising edge
//    reset     : asynchronous, active-low reset
//    rx_data   : incoming byte
//    rx_valid  : rx_data is valid
//    rx_ready  : loader accepts a byte this cycle
//    wr_en     : one-cycle instruction-memory write strobe
//    wr_addr   : word address of the write
//    wr_data   : instruction word to write
//    cpu_hold  : 1 holds the datapath in reset
//    done      : one-cycle pulse after a frame with a good checksum
//    error     : sticky, last frame failed (cleared by the next START_BYTE)
// ---------------------------------------------------------------------------
module imem_loader #(
   parameter int          ADDR_W         = 5,
   parameter logic [7:0]  START_BYTE     = 8'hA5,
   parameter int          TIMEOUT_CYCLES = 1024
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic              cpu_hold,
   output logic              done,
   output logic              error
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
   // One extra bit so a full-memory count (N = DEPTH) fits.
   localparam int WC_W  = ADDR_W + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_COUNT,
      S_DATA,
      S_CHECK,
      S_DONE,
      S_ERR
   } state_t;

   state_t              state_reg;
   logic                rx_ready_reg;
   logic                wr_en_reg;
   logic [ADDR_W-1:0]   wr_addr_reg;
   logic [31:0]         wr_data_reg;
   logic                cpu_hold_reg;
   logic                done_reg;
   logic                error_reg;

   logic [ADDR_W-1:0]   addr_reg;        // address of the word being assembled
   logic [WC_W-1:0]     words_left_reg;  // words still to receive, incl. current
   logic [1:0]          byte_idx_reg;    // byte position within the current word
   logic [23:0]         word_reg;        // first three bytes of the current word
   logic [7:0]          csum_reg;        // running XOR of data bytes
   logic [TO_W-1:0]     idle_cnt_reg;    // consecutive cycles without a byte

   logic accept;
   logic in_frame;
   logic timeout_hit;
   logic count_bad;

   assign accept   = rx_valid & rx_ready_reg;
   assign in_frame = (state_reg == S_COUNT) || (state_reg == S_DATA) ||
                     (state_reg == S_CHECK);
   // The idle count would reach TIMEOUT_CYCLES on this edge. An accepted
   // byte on the same edge takes priority, hence the !accept term.
   assign timeout_hit = in_frame && !accept &&
                        (idle_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));
   assign count_bad   = (rx_data == 8'h00) || (int'(rx_data) > DEPTH);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg      <= S_IDLE;
         rx_ready_reg   <= 1'b1;
         wr_en_reg      <= 1'b0;
         wr_addr_reg    <= '0;
         wr_data_reg    <= '0;
         cpu_hold_reg   <= 1'b1;
         done_reg       <= 1'b0;
         error_reg      <= 1'b0;
         addr_reg       <= '0;
         words_left_reg <= '0;
         byte_idx_reg   <= '0;
         word_reg       <= '0;
         csum_reg       <= '0;
         idle_cnt_reg   <= '0;
      end else begin
         // Strobes default low; they are raised for exactly one cycle below.
         wr_en_reg <= 1'b0;
         done_reg  <= 1'b0;

         if (in_frame) begin
            idle_cnt_reg <= accept ? '0 : idle_cnt_reg + 1'b1;
         end

         case (state_reg)
            S_IDLE: begin
               if (accept && (rx_data == START_BYTE)) begin
                  cpu_hold_reg <= 1'b1;
                  error_reg    <= 1'b0;
                  addr_reg     <= '0;
                  csum_reg     <= '0;
                  byte_idx_reg <= '0;
                  idle_cnt_reg <= '0;
                  state_reg    <= S_COUNT;
               end
            end

            S_COUNT: begin
               if (accept) begin
                  if (count_bad) begin
                     rx_ready_reg <= 1'b0;
                     state_reg    <= S_ERR;
                  end else begin
                     words_left_reg <= WC_W'(rx_data);
                     state_reg      <= S_DATA;
                  end
               end else if (timeout_hit) begin
                  rx_ready_reg <= 1'b0;
                  state_reg    <= S_ERR;
               end
            end

            S_DATA: begin
               if (accept) begin
                  word_reg     <= {word_reg[15:0], rx_data};
                  csum_reg     <= csum_reg ^ rx_data;
                  byte_idx_reg <= byte_idx_reg + 2'd1;
                  if (byte_idx_reg == 2'd3) begin
                     wr_en_reg      <= 1'b1;
                     wr_addr_reg    <= addr_reg;
                     wr_data_reg    <= {word_reg, rx_data};
                     addr_reg       <= addr_reg + 1'b1;
                     words_left_reg <= words_left_reg - 1'b1;
                     if (words_left_reg == WC_W'(1)) begin
                        state_reg <= S_CHECK;
                     end
                  end
               end else if (timeout_hit) begin
                  rx_ready_reg <= 1'b0;
                  state_reg    <= S_ERR;
               end
            end

            S_CHECK: begin
               if (accept) begin
                  rx_ready_reg <= 1'b0;
                  state_reg    <= (rx_data == csum_reg) ? S_DONE : S_ERR;
               end else if (timeout_hit) begin
                  rx_ready_reg <= 1'b0;
                  state_reg    <= S_ERR;
               end
            end

            S_DONE: begin
               done_reg     <= 1'b1;
               cpu_hold_reg <= 1'b0;
               rx_ready_reg <= 1'b1;
               state_reg    <= S_IDLE;
            end

            S_ERR: begin
               // Words already written stay in memory; cpu_hold stays set so
               // the partial program is never executed.
               error_reg    <= 1'b1;
               rx_ready_reg <= 1'b1;
               state_reg    <= S_IDLE;
            end

            default: begin
               rx_ready_reg <= 1'b1;
               state_reg    <= S_IDLE;
            end
         endcase
      end
   end

   assign rx_ready = rx_ready_reg;
   assign wr_en    = wr_en_reg;
   assign wr_addr  = wr_addr_reg;
   assign wr_data  = wr_data_reg;
   assign cpu_hold = cpu_hold_reg;
   assign done     = done_reg;
   assign error    = error_reg;

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//
// Self-checking bench for imem_loader. Expected writes are pushed to a
// scoreboard queue as frames are sent; a negedge monitor pops and compares
// them whenever wr_en is seen. Each scenario task checks its own timing.
// ---------------------------------------------------------------------------
module tb_imem_loader;

   localparam int ADDR_W = 5;

   typedef logic [ADDR_W+31:0] wr_entry_t;   // {addr, data}

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic [7:0]        rx_data = 8'h00;
   logic              rx_valid = 1'b0;
   logic              rx_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_data;
   logic              cpu_hold;
   logic              done;
   logic              error;

   int checks      = 0;
   int failures    = 0;
   int write_count = 0;
   int done_count  = 0;

   wr_entry_t   sb_q[$];
   logic [7:0]  payload[$];

   imem_loader #(
      .ADDR_W         (ADDR_W),
      .START_BYTE     (8'hA5),
      .TIMEOUT_CYCLES (1024)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .cpu_hold (cpu_hold),
      .done     (done),
      .error    (error)
   );

   always #5 clock = ~clock;

   // Scoreboard monitor: every write must match the oldest expected entry.
   always @(negedge clock) begin
      wr_entry_t exp_e;
      if (reset === 1'b1) begin
         if (wr_en === 1'b1) begin
            write_count++;
            checks++;
            if (sb_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_write got addr=%0d data=%h, none expected",
                        wr_addr, wr_data);
            end else begin
               exp_e = sb_q.pop_front();
               if ({wr_addr, wr_data} !== exp_e) begin
                  failures++;
                  $display("FAIL write_value got addr=%0d data=%h expected addr=%0d data=%h",
                           wr_addr, wr_data, exp_e[ADDR_W+31:32], exp_e[31:0]);
               end else begin
                  $display("write addr=%0d data=%h", wr_addr, wr_data);
               end
            end
         end
         if (done === 1'b1) done_count++;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Present one byte and hold it until accepted; returns 1 time unit after
   // the accepting edge.
   task automatic send_byte(input logic [7:0] b);
      int guard;
      guard = 0;
      @(negedge clock);
      while (rx_ready !== 1'b1 && guard < 100) begin
         @(negedge clock);
         guard++;
      end
      if (guard >= 100) begin
         checks++;
         failures++;
         $display("FAIL rx_ready_stuck got rx_ready=%b expected 1 within 100 cycles", rx_ready);
      end
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clock);
      #1;
      rx_valid = 1'b0;
   endtask

   // Send count byte, payload data and checksum; expected writes are queued
   // from addr 0. Returns 1 time unit after the checksum accept edge.
   task automatic send_body(input int nwords, input bit bad_sum);
      logic [7:0]  xs;
      logic [31:0] w;
      xs = 8'h00;
      send_byte(8'(nwords));
      for (int i = 0; i < nwords; i++) begin
         w = {payload[4*i], payload[4*i+1], payload[4*i+2], payload[4*i+3]};
         sb_q.push_back({ADDR_W'(i), w});
      end
      for (int i = 0; i < 4*nwords; i++) begin
         send_byte(payload[i]);
         xs ^= payload[i];
      end
      send_byte(bad_sum ? 8'h00 : xs);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      checks++;
      if ({rx_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error} !==
          {1'b1, 1'b0, {ADDR_W{1'b0}}, 32'h0, 1'b1, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL reset_values got rdy=%b we=%b a=%0d d=%h hold=%b done=%b err=%b expected 1 0 0 0 1 0 0",
                  rx_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error);
      end else $display("reset values ok");
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic test_good_load();
      logic [7:0]  bytes [8];
      logic [7:0]  xs;
      logic [31:0] w;
      bytes = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
      xs = 8'h00;
      sb_q.push_back({ADDR_W'(0), 32'h20080005});
      sb_q.push_back({ADDR_W'(1), 32'h8C090004});
      send_byte(8'hA5);
      send_byte(8'h02);
      for (int i = 0; i < 8; i++) begin
         send_byte(bytes[i]);
         xs ^= bytes[i];
         checks++;
         if (i % 4 == 3) begin
            w = {bytes[i-3], bytes[i-2], bytes[i-1], bytes[i]};
            if (wr_en !== 1'b1 || wr_addr !== ADDR_W'(i/4) || wr_data !== w) begin
               failures++;
               $display("FAIL good_write_latency got we=%b a=%0d d=%h expected 1 %0d %h",
                        wr_en, wr_addr, wr_data, i/4, w);
            end
         end else if (wr_en !== 1'b0) begin
            failures++;
            $display("FAIL good_no_early_write got we=%b expected 0 at byte %0d", wr_en, i);
         end
      end
      send_byte(xs);   // XOR of the eight data bytes = 8'hAC
      checks++;
      if (done !== 1'b0 || cpu_hold !== 1'b1 || rx_ready !== 1'b0) begin
         failures++;
         $display("FAIL good_done_state got done=%b hold=%b rdy=%b expected 0 1 0",
                  done, cpu_hold, rx_ready);
      end
      @(posedge clock); #1;
      checks++;
      if (done !== 1'b1 || cpu_hold !== 1'b0 || error !== 1'b0 || rx_ready !== 1'b1) begin
         failures++;
         $display("FAIL good_done_pulse got done=%b hold=%b err=%b rdy=%b expected 1 0 0 1",
                  done, cpu_hold, error, rx_ready);
      end else $display("good load done");
      @(posedge clock); #1;
      checks++;
      if (done !== 1'b0 || cpu_hold !== 1'b0) begin
         failures++;
         $display("FAIL good_done_width got done=%b hold=%b expected 0 0", done, cpu_hold);
      end
   endtask

   task automatic test_bad_checksum();
      int dc0;
      dc0 = done_count;
      payload.delete();
      payload = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
      send_byte(8'hA5);
      send_body(2, 1'b1);
      checks++;
      if (rx_ready !== 1'b0 || error !== 1'b0) begin
         failures++;
         $display("FAIL bad_err_state got rdy=%b err=%b expected 0 0", rx_ready, error);
      end
      @(posedge clock); #1;
      checks++;
      if (error !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0) begin
         failures++;
         $display("FAIL bad_checksum got err=%b hold=%b done=%b expected 1 1 0",
                  error, cpu_hold, done);
      end else $display("bad checksum flagged");
      repeat (3) @(posedge clock); #1;
      checks++;
      if (done_count !== dc0) begin
         failures++;
         $display("FAIL bad_no_done got done_pulses=%0d expected %0d", done_count, dc0);
      end
      // A good frame afterwards clears error on its start byte.
      send_byte(8'hA5);
      checks++;
      if (error !== 1'b0 || cpu_hold !== 1'b1) begin
         failures++;
         $display("FAIL recover_start got err=%b hold=%b expected 0 1", error, cpu_hold);
      end
      send_body(2, 1'b0);
      repeat (2) @(posedge clock); #1;
      checks++;
      if (cpu_hold !== 1'b0 || error !== 1'b0 || done_count !== dc0 + 1) begin
         failures++;
         $display("FAIL recover_end got hold=%b err=%b done_pulses=%0d expected 0 0 %0d",
                  cpu_hold, error, done_count, dc0 + 1);
      end else $display("recovery load done");
   endtask

   task automatic test_invalid_count();
      logic [7:0] counts [2];
      int wc0;
      counts = '{8'h00, 8'h21};
      wc0 = write_count;
      for (int k = 0; k < 2; k++) begin
         send_byte(8'hA5);
         send_byte(counts[k]);
         checks++;
         if (rx_ready !== 1'b0) begin
            failures++;
            $display("FAIL count_err_state got rdy=%b expected 0 for N=%h", rx_ready, counts[k]);
         end
         @(posedge clock); #1;
         checks++;
         if (error !== 1'b1 || cpu_hold !== 1'b1) begin
            failures++;
            $display("FAIL invalid_count got err=%b hold=%b expected 1 1 for N=%h",
                     error, cpu_hold, counts[k]);
         end else $display("invalid count %h flagged", counts[k]);
      end
      repeat (2) @(posedge clock); #1;
      checks++;
      if (write_count !== wc0) begin
         failures++;
         $display("FAIL invalid_count_writes got %0d expected %0d", write_count, wc0);
      end
   endtask

   task automatic test_timeout();
      int wc0;
      wc0 = write_count;
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h12);
      send_byte(8'h34);
      repeat (1023) @(posedge clock);
      #1;
      checks++;
      if (error !== 1'b0 || rx_ready !== 1'b1) begin
         failures++;
         $display("FAIL timeout_early got err=%b rdy=%b expected 0 1 after 1023 idle", error, rx_ready);
      end
      @(posedge clock); #1;
      checks++;
      if (rx_ready !== 1'b0) begin
         failures++;
         $display("FAIL timeout_err_state got rdy=%b expected 0 after 1024 idle", rx_ready);
      end
      @(posedge clock); #1;
      checks++;
      if (error !== 1'b1 || rx_ready !== 1'b1 || cpu_hold !== 1'b1) begin
         failures++;
         $display("FAIL timeout got err=%b rdy=%b hold=%b expected 1 1 1", error, rx_ready, cpu_hold);
      end else $display("timeout flagged");
      checks++;
      if (write_count !== wc0) begin
         failures++;
         $display("FAIL timeout_writes got %0d expected %0d", write_count, wc0);
      end
   endtask

   task automatic test_full_memory();
      int wc0;
      int dc0;
      wc0 = write_count;
      dc0 = done_count;
      send_byte(8'h3C);
      send_byte(8'hFF);
      repeat (2) @(posedge clock); #1;
      checks++;
      if (error !== 1'b1 || cpu_hold !== 1'b1 || rx_ready !== 1'b1) begin
         failures++;
         $display("FAIL noise_discard got err=%b hold=%b rdy=%b expected 1 1 1",
                  error, cpu_hold, rx_ready);
      end
      payload.delete();
      for (int i = 0; i < 128; i++) payload.push_back(8'($urandom_range(0, 255)));
      send_byte(8'hA5);
      send_body(32, 1'b0);
      repeat (3) @(posedge clock); #1;
      checks++;
      if (write_count !== wc0 + 32 || done_count !== dc0 + 1 || cpu_hold !== 1'b0 ||
          error !== 1'b0 || sb_q.size() != 0) begin
         failures++;
         $display("FAIL full_memory got writes=%0d done=%0d hold=%b err=%b pending=%0d expected %0d %0d 0 0 0",
                  write_count - wc0, done_count - dc0, cpu_hold, error, sb_q.size(), 32, 1);
      end else $display("full memory load done, 32 writes");
   endtask

   task automatic test_reset_mid_word();
      int wc0;
      wc0 = write_count;
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h11);
      send_byte(8'h22);
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if ({rx_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error} !==
          {1'b1, 1'b0, {ADDR_W{1'b0}}, 32'h0, 1'b1, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL async_reset got rdy=%b we=%b a=%0d d=%h hold=%b done=%b err=%b expected 1 0 0 0 1 0 0",
                  rx_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error);
      end else $display("async reset mid-word ok");
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      repeat (4) @(posedge clock); #1;
      checks++;
      if (write_count !== wc0) begin
         failures++;
         $display("FAIL reset_no_write got %0d expected %0d", write_count, wc0);
      end
      payload.delete();
      payload = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      send_byte(8'hA5);
      send_body(1, 1'b0);
      repeat (2) @(posedge clock); #1;
      checks++;
      if (cpu_hold !== 1'b0 || write_count !== wc0 + 1 || sb_q.size() != 0) begin
         failures++;
         $display("FAIL reset_reload got hold=%b writes=%0d pending=%0d expected 0 1 0",
                  cpu_hold, write_count - wc0, sb_q.size());
      end else $display("reload after reset done");
   endtask

   initial begin
      test_reset();
      test_good_load();
      test_bad_checksum();
      test_invalid_count();
      test_timeout();
      test_full_memory();
      test_reset_mid_word();
      repeat (2) @(posedge clock); #1;
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain got pending=%0d expected 0", sb_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
